// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
// Multi-cycle WIDTH-bit add/subtract unit. One 4-bit carry-lookahead slice
// is reused for every nibble, LSB first, one nibble per clock. The slice
// group carry is registered between nibbles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub captured on accept)
//   a, b                WIDTH-bit operands
//   cin                 carry-in for add, ignored for subtract
//   sub                 1: a - b (a + ~b + 1), 0: a + b + cin
//   out_valid/out_ready result handshake
//   sum                 WIDTH-bit result
//   cout                carry-out of the MSB nibble (for sub: 1 = no borrow)
//   overflow            signed overflow
//   zero                sum == 0
//   busy                high while computing or holding a result
module cla_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 4-bit carry-lookahead slice: returns {group carry-out, sum nibble}.
   function automatic logic [4:0] cla_slice(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       c0);
      logic [3:0] p;
      logic [3:0] g;
      logic [3:0] c;
      logic       gg;
      logic       pg;
      p    = x ^ y;
      g    = x & y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
      pg   = &p;
      return {gg | (pg & c0), p ^ c};
   endfunction

   state_t             state_r, state_next_s;
   logic [WIDTH-1:0]   op_a_r, op_a_next_s;
   logic [WIDTH-1:0]   op_b_r, op_b_next_s;
   logic               carry_r, carry_next_s;
   logic [IDX_W-1:0]   idx_r, idx_next_s;
   logic [WIDTH-1:0]   sum_r, sum_next_s;
   logic               cout_r, cout_next_s;
   logic               overflow_r, overflow_next_s;
   logic               zero_r, zero_next_s;
   logic               out_valid_r, out_valid_next_s;
   logic               in_ready_r, in_ready_next_s;
   logic               busy_r, busy_next_s;

   logic [IDX_W+1:0]   base_s;
   logic [4:0]         slice_s;
   logic               last_s;

   assign base_s  = {idx_r, 2'b00};
   assign slice_s = cla_slice(op_a_r[base_s +: 4], op_b_r[base_s +: 4], carry_r);
   assign last_s  = (idx_r == IDX_W'(NIBBLES - 1));

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         op_a_r      <= {WIDTH{1'b0}};
         op_b_r      <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         idx_r       <= {IDX_W{1'b0}};
         sum_r       <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         op_a_r      <= op_a_next_s;
         op_b_r      <= op_b_next_s;
         carry_r     <= carry_next_s;
         idx_r       <= idx_next_s;
         sum_r       <= sum_next_s;
         cout_r      <= cout_next_s;
         overflow_r  <= overflow_next_s;
         zero_r      <= zero_next_s;
         out_valid_r <= out_valid_next_s;
         in_ready_r  <= in_ready_next_s;
         busy_r      <= busy_next_s;
      end
   end

   // Next-state and next-output logic; handshake outputs are computed one
   // cycle ahead so that they leave the block straight from flops.
   always_comb begin
      state_next_s     = state_r;
      op_a_next_s      = op_a_r;
      op_b_next_s      = op_b_r;
      carry_next_s     = carry_r;
      idx_next_s       = idx_r;
      sum_next_s       = sum_r;
      cout_next_s      = cout_r;
      overflow_next_s  = overflow_r;
      zero_next_s      = zero_r;
      out_valid_next_s = out_valid_r;
      in_ready_next_s  = in_ready_r;
      busy_next_s      = busy_r;

      case (state_r)
         IDLE: begin
            if (in_valid) begin
               op_a_next_s      = a;
               op_b_next_s      = sub ? ~b : b;
               carry_next_s     = sub ? 1'b1 : cin;
               idx_next_s       = {IDX_W{1'b0}};
               sum_next_s       = {WIDTH{1'b0}};
               state_next_s     = RUN;
               in_ready_next_s  = 1'b0;
               busy_next_s      = 1'b1;
               out_valid_next_s = 1'b0;
            end else begin
               in_ready_next_s  = 1'b1;
               busy_next_s      = 1'b0;
               out_valid_next_s = 1'b0;
            end
         end
         RUN: begin
            sum_next_s[base_s +: 4] = slice_s[3:0];
            carry_next_s            = slice_s[4];
            if (last_s) begin
               // Flags are taken from the sum including this final nibble.
               idx_next_s       = {IDX_W{1'b0}};
               cout_next_s      = slice_s[4];
               overflow_next_s  = (op_a_r[WIDTH-1] == op_b_r[WIDTH-1])
                                & (sum_next_s[WIDTH-1] != op_a_r[WIDTH-1]);
               zero_next_s      = (sum_next_s == {WIDTH{1'b0}});
               out_valid_next_s = 1'b1;
               state_next_s     = DONE;
            end else begin
               idx_next_s       = idx_r + IDX_W'(1);
            end
         end
         DONE: begin
            // in_ready stays low here: no accept on the result handshake edge.
            if (out_ready) begin
               out_valid_next_s = 1'b0;
               in_ready_next_s  = 1'b1;
               busy_next_s      = 1'b0;
               state_next_s     = IDLE;
            end else begin
               out_valid_next_s = 1'b1;
            end
         end
         default: begin
            state_next_s     = IDLE;
            out_valid_next_s = 1'b0;
            in_ready_next_s  = 1'b1;
            busy_next_s      = 1'b0;
         end
      endcase
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign overflow  = overflow_r;
   assign zero      = zero_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=16) using a result
// scoreboard: expected results are queued on accept, checked on output.
module tb_cla_nibble_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;
   logic        zero;
   logic        busy;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ov;
      logic        zero;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   acc_cyc = 0;

   cla_nibble_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(overflow), .zero(zero),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                  input logic xcin, input logic xsub);
      exp_t        e;
      logic [16:0] t;
      t = {1'b0, xa} + (xsub ? (17'h10000 - {1'b0, xb}) : {1'b0, xb})
        + (xsub ? 17'd0 : {16'd0, xcin});
      e.sum  = t[15:0];
      // For subtract, cout means "no borrow": a >= b unsigned.
      e.cout = xsub ? (xa >= xb) : t[16];
      if (xsub) e.ov = (xa[15] != xb[15]) && (e.sum[15] != xa[15]);
      else      e.ov = (xa[15] == xb[15]) && (e.sum[15] != xa[15]);
      e.zero = (e.sum == 16'h0000);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] xa, input logic [15:0] xb,
                       input logic xcin, input logic xsub, input bit push);
      int n = 0;
      a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
      if (push) exp_q.push_back(model(xa, xb, xcin, xsub));
      tick();
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input int hold, input int lat);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (lat >= 0) check({tag, "_latency"}, cyc - acc_cyc, lat);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      for (int i = 0; i < hold; i++) begin
         check({tag, "_hold_valid"}, out_valid, 1'b1);
         check({tag, "_hold_sum"}, sum, e.sum);
         check({tag, "_hold_flags"}, {cout, overflow, zero}, {e.cout, e.ov, e.zero});
         check({tag, "_hold_in_ready"}, in_ready, 1'b0);
         tick();
      end
      check({tag, "_sum"}, sum, e.sum);
      check({tag, "_cout"}, cout, e.cout);
      check({tag, "_ovf"}, overflow, e.ov);
      check({tag, "_zero"}, zero, e.zero);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_clr"}, out_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sum", sum, 16'h0000);
      check("rst_flags", {cout, overflow, zero}, 3'b000);

      // Directed add, latency check.
      send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);
      check("run_busy", busy, 1'b1);
      recv("add", 0, 4);
      check("add_sum_const", sum, 16'h2201);

      // Carry ripples through every nibble.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      recv("ripple", 0, 4);

      // Subtract with and without signed overflow.
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
      recv("sub_ovf", 0, 4);
      send(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
      recv("sub_neg", 0, 4);

      // Backpressure with new operands waiting.
      send(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1);
      a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      recv("bp", 5, 4);
      check("bp_no_accept_busy", busy, 1'b0);
      check("bp_idle_in_ready", in_ready, 1'b1);
      exp_q.push_back(model(16'h4000, 16'h4000, 1'b0, 1'b0));
      tick();
      acc_cyc  = cyc;
      in_valid = 1'b0;
      check("bp_accepted_busy", busy, 1'b1);
      recv("bp_next", 0, 4);

      // Reset after two nibbles have been processed.
      send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_sum", sum, 16'h0000);
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_busy", busy, 1'b0);
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
      recv("post_rst", 0, 4);

      // Carry-in add; inputs scrambled during RUN must not matter.
      send(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b1;
      tick();
      a = 16'h5555; b = 16'hAAAA;
      recv("cin_ovf", 0, 4);
      check("cin_ovf_sum_const", sum, 16'h8000);

      // Random mix.
      for (int i = 0; i < 8; i++) begin
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         recv("rand", 0, 4);
      end

      check("sb_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
